axis_rr_packet_arbiter: RTL and testbench
=========================================

Name: axis_rr_packet_arbiter

Overview:
- Shares one AXI-stream output between NUM_MASTERS packet sources.
- Uses round-robin arbitration at packet granularity.
- A grant is held until the granted master's tlast beat is accepted.
- The output is forward-registered: data/last/valid are registered, and ready passes through combinationally.
- Sits in front of shared egress datapaths, such as the virtualized network port, so that several vFPGA regions can share a single forward register stage.

Parameters:
- DATA_WIDTH, 64, data width of every stream in bits.
- NUM_MASTERS, 4, number of requesting input streams; legal range 2..16.
- ID_WIDTH, $clog2(NUM_MASTERS), width of grant_id; derived, not overridden.

Ports:
- clk  in  1  clock; all interfaces synchronous to it.
- reset  in  1  synchronous, active-high reset.
- in_data  in  NUM_MASTERS*DATA_WIDTH  packed input data; master i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_last  in  NUM_MASTERS  per-master tlast.
- in_valid  in  NUM_MASTERS  per-master tvalid.
- in_ready  out  NUM_MASTERS  per-master tready.
- out_data  out  DATA_WIDTH  registered output data.
- out_last  out  1  registered output tlast.
- out_valid  out  1  registered output tvalid.
- out_ready  in  1  downstream backpressure.
- grant_id  out  ID_WIDTH  index of the currently or most recently granted master.
- busy  out  1  high while in LOCKED.

Behaviour:
- Reset (synchronous, active-high; takes priority over all else):
  - state=IDLE, out_valid=0, out_last=0, in_ready=0.
  - last_grant=NUM_MASTERS-1, so master 0 has first priority; grant_id=0.
  - out_data is not reset.
- Reset mid-packet: the lock is dropped immediately and the partial packet is truncated; upstream sources must also be reset.
- IDLE:
  - in_ready = all zeros.
  - Search order is last_grant+1, last_grant+2, ... modulo NUM_MASTERS.
  - The first master with in_valid=1 wins. On the next edge: state<=LOCKED, grant<=winner, grant_id<=winner.
  - No request: stay in IDLE.
  - The arbitration cycle consumes no beat.
- LOCKED (granted index g):
  - in_ready[g] = out_ready; all other in_ready bits = 0.
  - A beat is accepted when in_valid[g] && out_ready.
  - An accepted beat with in_last[g]=1 sets state<=IDLE and last_grant<=g on that edge.
  - in_valid[g]=0 while locked: hold the lock indefinitely (no timeout). out_valid drops to 0 on the next out_ready edge.
- Output register (forward slice): on each edge with out_ready=1, it loads:
  - out_data <= in_data[g]
  - out_last <= in_last[g]
  - out_valid <= (state==LOCKED) && in_valid[g]
  With out_ready=0 the register and all outputs hold.
- Latency:
  - A request arriving in IDLE at cycle 0 sees in_ready high at cycle 1 (if out_ready=1). The first beat appears on out_* at cycle 2.
  - Subsequent beats have one-cycle latency at full throughput.
  - Each packet costs one arbitration bubble cycle.
- A master that raises valid while another master is locked waits. It is considered at the next IDLE cycle.
- Fairness: with all masters continuously requesting, grants rotate 0,1,2,...,N-1,0,...
- grant_id is only meaningful while busy=1 or while out_valid=1.
- No combinational path exists from in_valid to in_ready.

Optional Feature:
- Macro ARB_HIGH_PRIO_EN.
- When defined:
  - In IDLE, master 0 wins whenever in_valid[0]=1, regardless of round-robin position.
  - Otherwise, masters 1..N-1 are searched round-robin from last_grant+1, skipping 0.
  - A grant to master 0 does not update last_grant.
  - An in-flight packet is never pre-empted.
- When undefined: pure round-robin as described above.

Test Plan:
- Single packet: reset, then master 2 sends 3 beats (data 0xA1,0xA2,0xA3, last on the third) with out_ready=1. Required: in_ready[2] high cycles 1-3; out_valid cycles 2-4 with 0xA1..0xA3; out_last only with 0xA3; grant_id=2; busy falls after cycle 3.
- Fairness: all 4 masters continuously send 1-beat packets. Required: out_data source sequence 0,1,2,3,0,1; one valid beat every 2 cycles.
- Lock hold: master 1 is mid-packet (2 of 4 beats sent) while master 0 asserts valid. Required: in_ready[0] stays 0 until master 1's last beat is accepted; master 0 is granted on the next IDLE cycle.
- Backpressure: out_ready=0 for 5 cycles mid-packet. Required: out_data/out_valid/out_last hold; in_ready[g]=0 throughout; no beat is lost or duplicated; the sequence resumes exactly when out_ready returns to 1.
- Reset mid-packet: assert reset during beat 2 of a 4-beat packet. Required: next cycle out_valid=0, busy=0, in_ready=0; after release, master 0 has priority if all request.
- ARB_HIGH_PRIO_EN: masters 0 and 3 request repeatedly. Required: master 0 wins every arbitration; master 3 is granted only in IDLE cycles where in_valid[0]=0.

Source files
------------

// File: rtl/axis_rr_packet_arbiter.sv
// Round-robin packet arbiter sharing one forward-registered AXI-stream output.
// Optional ARB_HIGH_PRIO_EN: master 0 wins every arbitration it requests.
module axis_rr_packet_arbiter #(
  parameter int DATA_WIDTH  = 64,
  parameter int NUM_MASTERS = 4,
  localparam int ID_WIDTH   = $clog2(NUM_MASTERS)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_MASTERS-1:0]            in_last,
  input  logic [NUM_MASTERS-1:0]            in_valid,
  output logic [NUM_MASTERS-1:0]            in_ready,
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic                              out_last,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [ID_WIDTH-1:0]               grant_id,
  output logic                              busy
);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_e;

  state_e state_q, state_d;

  logic [ID_WIDTH-1:0]   grant_q, grant_d;
  logic [ID_WIDTH-1:0]   last_q, last_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  olast_q;
  logic                  ovalid_q;

  logic [DATA_WIDTH-1:0] in_arr [NUM_MASTERS];
  logic                  found;
  logic [ID_WIDTH-1:0]   winner;
  logic [ID_WIDTH-1:0]   cand;
  logic                  accept;

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_unpack
    assign in_arr[i] = in_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Search starts one past the last completed grant.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
`ifdef ARB_HIGH_PRIO_EN
    if (in_valid[0]) begin
      found  = 1'b1;
      winner = '0;
    end
`endif
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      cand = ID_WIDTH'((int'(last_q) + k) % NUM_MASTERS);
`ifdef ARB_HIGH_PRIO_EN
      if (!found && cand != '0 && in_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
`else
      if (!found && in_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
`endif
    end
  end

  assign accept = (state_q == LOCKED) && in_valid[grant_q] && out_ready;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = LOCKED;
          grant_d = winner;
        end
      end
      LOCKED: begin
        if (accept && in_last[grant_q]) begin
          state_d = IDLE;
`ifdef ARB_HIGH_PRIO_EN
          if (grant_q != '0) begin
            last_d = grant_q;
          end
`else
          last_d = grant_q;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = '0;
    if (state_q == LOCKED) begin
      in_ready[grant_q] = out_ready;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= ID_WIDTH'(NUM_MASTERS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ovalid_q <= 1'b0;
      olast_q  <= 1'b0;
    end else if (out_ready) begin
      ovalid_q <= (state_q == LOCKED) && in_valid[grant_q];
      olast_q  <= in_last[grant_q];
    end
  end

  // Payload register carries no reset; out_valid qualifies it.
  always_ff @(posedge clk) begin
    if (out_ready) begin
      data_q <= in_arr[grant_q];
    end
  end

  assign out_data  = data_q;
  assign out_last  = olast_q;
  assign out_valid = ovalid_q;
  assign grant_id  = grant_q;
  assign busy      = (state_q == LOCKED);

endmodule

// File: tb/tb_axis_rr_packet_arbiter.sv
// Bench for axis_rr_packet_arbiter: queue-fed sources, spec-level model,
// directed scenarios plus randomized traffic.
module tb_axis_rr_packet_arbiter;

  localparam int DW = 64;
  localparam int N  = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]  in_last, in_valid, in_ready;
  logic [DW-1:0] out_data;
  logic          out_last, out_valid, out_ready;
  logic [IW-1:0] grant_id;
  logic          busy;

  axis_rr_packet_arbiter #(.DATA_WIDTH(DW), .NUM_MASTERS(N)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  logic [64:0] mem [N][16];
  int  wr [N];
  int  rd [N];
  bit  cur_v [N];
  bit  en [N];
  int  pkt [N];
  logic [N-1:0] rdy_s;
  int  sent = 0;
  int  dlv_cnt = 0;

  bit          m_busy;
  int          m_gid;
  int          m_lg;
  bit          m_ov;
  bit          m_ol;
  logic [63:0] m_od;

  logic [N-1:0] rec_ir [8192];
  bit           rec_ov [8192];
  logic [63:0]  rec_od [8192];
  bit           rec_ol [8192];
  bit           rec_busy [8192];
  logic [IW-1:0] rec_gid [8192];

  logic [63:0] dlv_d [$];
  int          dlv_c [$];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h want %h", nm, cyc, act, exp);
    end
  endtask

  function automatic int pick();
`ifdef ARB_HIGH_PRIO_EN
    if (in_valid[0]) return 0;
`endif
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (m_lg + k) % N;
`ifdef ARB_HIGH_PRIO_EN
      if (idx == 0) continue;
`endif
      if (in_valid[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic load(int m, int n, logic [63:0] base);
    if (rd[m] == wr[m]) begin
      rd[m] = 0;
      wr[m] = 0;
    end
    for (int k = 0; k < n; k++) begin
      mem[m][wr[m]] = {(k == n - 1), base + 64'(k)};
      wr[m]++;
    end
  endtask

  task automatic drive();
    for (int m = 0; m < N; m++) begin
      if (!cur_v[m] && rd[m] < wr[m] && en[m]) cur_v[m] = 1'b1;
      in_valid[m] = cur_v[m];
      if (cur_v[m]) begin
        in_data[m*DW +: DW] = mem[m][rd[m]][63:0];
        in_last[m] = mem[m][rd[m]][64];
      end else begin
        in_data[m*DW +: DW] = {32'($urandom), 32'($urandom)};
        in_last[m] = 1'($urandom);
      end
    end
  endtask

  task automatic model_edge();
    int w;
    if (reset) begin
      m_busy = 1'b0;
      m_lg   = N - 1;
      m_gid  = 0;
      m_ov   = 1'b0;
      m_ol   = 1'b0;
    end else begin
      if (out_ready) begin
        m_ov = m_busy && in_valid[m_gid];
        m_od = in_data[m_gid*DW +: DW];
        m_ol = in_last[m_gid];
      end
      if (m_busy) begin
        if (out_ready && in_valid[m_gid] && in_last[m_gid]) begin
          m_busy = 1'b0;
`ifdef ARB_HIGH_PRIO_EN
          if (m_gid != 0) m_lg = m_gid;
`else
          m_lg = m_gid;
`endif
        end
      end else begin
        w = pick();
        if (w >= 0) begin
          m_busy = 1'b1;
          m_gid  = w;
        end
      end
    end
  endtask

  task automatic src_edge();
    for (int m = 0; m < N; m++) begin
      if (reset) begin
        rd[m] = 0;
        wr[m] = 0;
        cur_v[m] = 1'b0;
      end else if (cur_v[m] && rdy_s[m]) begin
        rd[m]++;
        cur_v[m] = 1'b0;
        sent++;
      end
    end
  endtask

  task automatic cycle();
    logic [N-1:0] exp_ir;
    drive();
    #1;
    exp_ir = '0;
    if (m_busy) exp_ir[m_gid] = out_ready;
    if (chk_en) begin
      chk("out_valid", 64'(out_valid), 64'(m_ov));
      chk("busy", 64'(busy), 64'(m_busy));
      chk("in_ready", 64'(in_ready), 64'(exp_ir));
      if (m_ov) begin
        chk("out_data", out_data, m_od);
        chk("out_last", 64'(out_last), 64'(m_ol));
      end
      if (m_busy || m_ov) chk("grant_id", 64'(grant_id), 64'(m_gid));
    end
    if (cyc < 8192) begin
      rec_ir[cyc]   = in_ready;
      rec_ov[cyc]   = out_valid;
      rec_od[cyc]   = out_data;
      rec_ol[cyc]   = out_last;
      rec_busy[cyc] = busy;
      rec_gid[cyc]  = grant_id;
    end
    if (out_valid && out_ready && !reset) begin
      dlv_d.push_back(out_data);
      dlv_c.push_back(cyc);
      dlv_cnt++;
    end
    rdy_s = in_ready;
    @(posedge clk);
    model_edge();
    src_edge();
    cyc++;
    @(negedge clk);
  endtask

  function automatic logic [63:0] dlv_at(int i);
    return (i < dlv_d.size()) ? dlv_d[i] : '1;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    bit hit;
    int stalls;
    bit done;
    int fexp [6];
    in_valid  = '0;
    in_last   = '0;
    in_data   = '0;
    out_ready = 1'b1;
    reset     = 1'b1;
    m_busy = 1'b0; m_gid = 0; m_lg = N - 1;
    m_ov = 1'b0; m_ol = 1'b0; m_od = '0;
    for (int m = 0; m < N; m++) begin
      wr[m] = 0; rd[m] = 0; cur_v[m] = 1'b0; en[m] = 1'b1; pkt[m] = 0;
    end
    @(negedge clk);

    cycle();
    chk_en = 1'b1;
    cycle();
    reset = 1'b0;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_grant_id", 64'(grant_id), 64'd0);

    // Single 3-beat packet from master 2
    load(2, 3, 64'hA1);
    t0 = cyc;
    repeat (6) cycle();
    chk("sp_ir_c0", 64'(rec_ir[t0]), 64'd0);
    for (int k = 1; k <= 3; k++)
      chk("sp_ir", 64'(rec_ir[t0+k]), 64'h4);
    chk("sp_ir_c4", 64'(rec_ir[t0+4]), 64'd0);
    chk("sp_ov_c1", 64'(rec_ov[t0+1]), 64'd0);
    for (int k = 0; k < 3; k++) begin
      chk("sp_ov", 64'(rec_ov[t0+2+k]), 64'd1);
      chk("sp_od", rec_od[t0+2+k], 64'hA1 + 64'(k));
      chk("sp_ol", 64'(rec_ol[t0+2+k]), 64'(k == 2));
    end
    chk("sp_gid", 64'(rec_gid[t0+2]), 64'd2);
    chk("sp_busy_c3", 64'(rec_busy[t0+3]), 64'd1);
    chk("sp_busy_c4", 64'(rec_busy[t0+4]), 64'd0);
    chk("sp_ov_c5", 64'(rec_ov[t0+5]), 64'd0);

    // Fairness: all masters with single-beat packets from reset
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    for (int m = 0; m < N; m++) begin
      load(m, 1, 64'hF0 + 64'(m));
      load(m, 1, 64'hF0 + 64'(m));
    end
`ifdef ARB_HIGH_PRIO_EN
    fexp = '{0, 0, 1, 2, 3, 1};
`else
    fexp = '{0, 1, 2, 3, 0, 1};
`endif
    dlv_d.delete();
    dlv_c.delete();
    repeat (24) cycle();
    for (int i = 0; i < 6; i++) begin
      chk("fair_src", dlv_at(i), 64'hF0 + 64'(fexp[i]));
      if (i > 0)
        chk("fair_gap", 64'((i < dlv_c.size()) ? dlv_c[i] - dlv_c[i-1] : -1), 64'd2);
    end

    // Lock hold: master 0 raises valid mid-packet of master 1
    load(1, 4, 64'hB0);
    en[0] = 1'b0;
    load(0, 1, 64'hC0);
    dlv_d.delete();
    dlv_c.delete();
    for (int i = 0; i < 30; i++) begin
      if (rd[1] >= 2) en[0] = 1'b1;
      cycle();
    end
    for (int i = 0; i < 4; i++)
      chk("lock_seq", dlv_at(i), 64'hB0 + 64'(i));
    chk("lock_m0_next", dlv_at(4), 64'hC0);

    // Backpressure: 5 stalled cycles mid-packet
    load(3, 4, 64'hD0);
    dlv_d.delete();
    dlv_c.delete();
    stalls = 0;
    for (int i = 0; i < 30; i++) begin
      if (dlv_d.size() >= 1 && stalls < 5) begin
        out_ready = 1'b0;
        stalls++;
      end else begin
        out_ready = 1'b1;
      end
      cycle();
    end
    chk("bp_count", 64'(dlv_d.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      chk("bp_seq", dlv_at(i), 64'hD0 + 64'(i));

    // Reset during beat 2 of a 4-beat packet
    load(2, 4, 64'hE0);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (rd[2] == 1) begin
        reset = 1'b1;
        hit = 1'b1;
      end
      cycle();
    end
    reset = 1'b0;
    chk("rm_reached", 64'(hit), 64'd1);
    chk("rm_out_valid", 64'(out_valid), 64'd0);
    chk("rm_busy", 64'(busy), 64'd0);
    chk("rm_in_ready", 64'(in_ready), 64'd0);
    for (int m = 0; m < N; m++) load(m, 1, 64'h70 + 64'(m));
    dlv_d.delete();
    dlv_c.delete();
    repeat (14) cycle();
    chk("rm_first_m0", dlv_at(0), 64'h70);

`ifdef ARB_HIGH_PRIO_EN
    // Masters 0 and 3 compete repeatedly
    repeat (60) begin
      en[0] = ($urandom_range(0, 2) != 0);
      en[3] = 1'b1;
      if (rd[0] == wr[0]) load(0, $urandom_range(1, 2), {8'd0, 24'(pkt[0]++), 32'd0});
      if (rd[3] == wr[3]) load(3, $urandom_range(1, 2), {8'd3, 24'(pkt[3]++), 32'd0});
      cycle();
    end
`endif

    // Quiesce, then randomized traffic
    for (int m = 0; m < N; m++) en[m] = 1'b1;
    out_ready = 1'b1;
    repeat (30) cycle();
    sent = 0;
    dlv_cnt = 0;
    repeat (2000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      for (int m = 0; m < N; m++) begin
        en[m] = ($urandom_range(0, 2) != 0);
        if (rd[m] == wr[m] && $urandom_range(0, 3) == 0)
          load(m, $urandom_range(1, 4), {8'(m), 24'(pkt[m]++), 32'd0});
      end
      cycle();
    end
    for (int m = 0; m < N; m++) en[m] = 1'b1;
    out_ready = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      cycle();
      done = !m_busy && !m_ov;
      for (int m = 0; m < N; m++)
        if (rd[m] != wr[m]) done = 1'b0;
    end
    chk("drain_done", 64'(done), 64'd1);
    chk("beats_conserved", 64'(dlv_cnt), 64'(sent));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
